// File: rtl/id_exe_register.sv
// ID/EXE pipeline register: one-cycle capture of decoded instruction fields with flush, freeze and async reset.
// Optional write-back bypass into the operand fields is enabled by defining ID_EXE_WB_BYPASS_EN.
module id_exe_register #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Freeze,
  input  logic                  i_Flush,
  input  logic                  i_Valid,
  input  logic [DATA_WIDTH-1:0] i_PC,
  input  logic [DATA_WIDTH-1:0] i_Val_Rn,
  input  logic [DATA_WIDTH-1:0] i_Val_Rm,
  input  logic [11:0]           i_Shift_Operand,
  input  logic                  i_Immediate,
  input  logic [3:0]            i_Dest,
  input  logic [3:0]            i_Src1,
  input  logic [3:0]            i_Src2,
  input  logic [3:0]            i_Exe_Cmd,
  input  logic                  i_Mem_Read,
  input  logic                  i_Mem_Write,
  input  logic                  i_WB_En,
  input  logic                  i_Set_Status,
  input  logic                  i_Branch,
  input  logic                  i_Carry,
  input  logic                  i_WB_Bypass_En,
  input  logic [3:0]            i_WB_Bypass_Dest,
  input  logic [DATA_WIDTH-1:0] i_WB_Bypass_Value,
  output logic [DATA_WIDTH-1:0] o_PC,
  output logic [DATA_WIDTH-1:0] o_Val_Rn,
  output logic [DATA_WIDTH-1:0] o_Val_Rm,
  output logic [11:0]           o_Shift_Operand,
  output logic                  o_Immediate,
  output logic [3:0]            o_Dest,
  output logic [3:0]            o_Src1,
  output logic [3:0]            o_Src2,
  output logic [3:0]            o_Exe_Cmd,
  output logic                  o_Mem_Read,
  output logic                  o_Mem_Write,
  output logic                  o_WB_En,
  output logic                  o_Set_Status,
  output logic                  o_Branch,
  output logic                  o_Carry,
  output logic                  o_Sig_Memory_Instruction,
  output logic                  o_Valid
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] val_rn;
    logic [DATA_WIDTH-1:0] val_rm;
    logic [11:0]           shift_operand;
    logic                  immediate;
    logic [3:0]            dest;
    logic [3:0]            src1;
    logic [3:0]            src2;
    logic [3:0]            exe_cmd;
    logic                  mem_read;
    logic                  mem_write;
    logic                  wb_en;
    logic                  set_status;
    logic                  branch;
    logic                  carry;
    logic                  sig_mem;
  } stage_t;

  stage_t stage_d, stage_q;

  always_comb begin
    stage_d = stage_q;
    if (i_Flush) begin
      stage_d = '0;
    end else if (!i_Freeze) begin
      stage_d.valid         = i_Valid;
      stage_d.pc            = i_PC;
      stage_d.val_rn        = i_Val_Rn;
      stage_d.val_rm        = i_Val_Rm;
      stage_d.shift_operand = i_Shift_Operand;
      stage_d.immediate     = i_Immediate;
      stage_d.dest          = i_Dest;
      stage_d.src1          = i_Src1;
      stage_d.src2          = i_Src2;
      stage_d.exe_cmd       = i_Exe_Cmd;
      stage_d.carry         = i_Carry;
      // A bubble keeps its data fields but may never carry side-effecting control bits.
      stage_d.mem_read      = i_Valid & i_Mem_Read;
      stage_d.mem_write     = i_Valid & i_Mem_Write;
      stage_d.wb_en         = i_Valid & i_WB_En;
      stage_d.set_status    = i_Valid & i_Set_Status;
      stage_d.branch        = i_Valid & i_Branch;
      stage_d.sig_mem       = i_Valid & (i_Mem_Read | i_Mem_Write);
`ifdef ID_EXE_WB_BYPASS_EN
      // R15 (dest 4'hF) is never forwarded; both operands take the value if both match.
      if (i_Valid && i_WB_Bypass_En && (i_WB_Bypass_Dest != 4'hF)) begin
        if (i_WB_Bypass_Dest == i_Src1) stage_d.val_rn = i_WB_Bypass_Value;
        if (i_WB_Bypass_Dest == i_Src2) stage_d.val_rm = i_WB_Bypass_Value;
      end
`endif
    end
  end

`ifndef ID_EXE_WB_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{i_WB_Bypass_En, i_WB_Bypass_Dest, i_WB_Bypass_Value};
`endif

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_Valid                  = stage_q.valid;
  assign o_PC                     = stage_q.pc;
  assign o_Val_Rn                 = stage_q.val_rn;
  assign o_Val_Rm                 = stage_q.val_rm;
  assign o_Shift_Operand          = stage_q.shift_operand;
  assign o_Immediate              = stage_q.immediate;
  assign o_Dest                   = stage_q.dest;
  assign o_Src1                   = stage_q.src1;
  assign o_Src2                   = stage_q.src2;
  assign o_Exe_Cmd                = stage_q.exe_cmd;
  assign o_Mem_Read               = stage_q.mem_read;
  assign o_Mem_Write              = stage_q.mem_write;
  assign o_WB_En                  = stage_q.wb_en;
  assign o_Set_Status             = stage_q.set_status;
  assign o_Branch                 = stage_q.branch;
  assign o_Carry                  = stage_q.carry;
  assign o_Sig_Memory_Instruction = stage_q.sig_mem;

endmodule

// File: tb/tb_id_exe_register.sv
// Bench for id_exe_register: directed vectors, expected outputs queued per edge and
// compared by a monitor one step after each rising edge; a few fields are also checked by hand.
module tb_id_exe_register;

  localparam int DW = 32;
  localparam int W  = 1 + 3*DW + 12 + 1 + 16 + 7;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] rn;
    logic [DW-1:0] rm;
    logic [11:0]   shop;
    logic          imm;
    logic [3:0]    dest;
    logic [3:0]    src1;
    logic [3:0]    src2;
    logic [3:0]    cmd;
    logic          mr;
    logic          mw;
    logic          wb;
    logic          ss;
    logic          br;
    logic          carry;
    logic          byp_en;
    logic [3:0]    byp_dest;
    logic [DW-1:0] byp_val;
  } in_t;

  logic clk = 1'b0;
  logic i_Reset, i_Freeze, i_Flush, i_Valid;
  logic [DW-1:0] i_PC, i_Val_Rn, i_Val_Rm, i_WB_Bypass_Value;
  logic [11:0] i_Shift_Operand;
  logic i_Immediate, i_Mem_Read, i_Mem_Write, i_WB_En, i_Set_Status, i_Branch, i_Carry;
  logic [3:0] i_Dest, i_Src1, i_Src2, i_Exe_Cmd, i_WB_Bypass_Dest;
  logic i_WB_Bypass_En;
  logic [DW-1:0] o_PC, o_Val_Rn, o_Val_Rm;
  logic [11:0] o_Shift_Operand;
  logic o_Immediate, o_Mem_Read, o_Mem_Write, o_WB_En, o_Set_Status, o_Branch, o_Carry;
  logic o_Sig_Memory_Instruction, o_Valid;
  logic [3:0] o_Dest, o_Src1, o_Src2, o_Exe_Cmd;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  logic [W-1:0] act_w;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_exe_register #(.DATA_WIDTH(DW)) dut (
    .i_Clk(clk), .i_Reset(i_Reset), .i_Freeze(i_Freeze), .i_Flush(i_Flush), .i_Valid(i_Valid),
    .i_PC(i_PC), .i_Val_Rn(i_Val_Rn), .i_Val_Rm(i_Val_Rm), .i_Shift_Operand(i_Shift_Operand),
    .i_Immediate(i_Immediate), .i_Dest(i_Dest), .i_Src1(i_Src1), .i_Src2(i_Src2),
    .i_Exe_Cmd(i_Exe_Cmd), .i_Mem_Read(i_Mem_Read), .i_Mem_Write(i_Mem_Write), .i_WB_En(i_WB_En),
    .i_Set_Status(i_Set_Status), .i_Branch(i_Branch), .i_Carry(i_Carry),
    .i_WB_Bypass_En(i_WB_Bypass_En), .i_WB_Bypass_Dest(i_WB_Bypass_Dest),
    .i_WB_Bypass_Value(i_WB_Bypass_Value),
    .o_PC(o_PC), .o_Val_Rn(o_Val_Rn), .o_Val_Rm(o_Val_Rm), .o_Shift_Operand(o_Shift_Operand),
    .o_Immediate(o_Immediate), .o_Dest(o_Dest), .o_Src1(o_Src1), .o_Src2(o_Src2),
    .o_Exe_Cmd(o_Exe_Cmd), .o_Mem_Read(o_Mem_Read), .o_Mem_Write(o_Mem_Write), .o_WB_En(o_WB_En),
    .o_Set_Status(o_Set_Status), .o_Branch(o_Branch), .o_Carry(o_Carry),
    .o_Sig_Memory_Instruction(o_Sig_Memory_Instruction), .o_Valid(o_Valid)
  );

  assign act_w = {o_Valid, o_PC, o_Val_Rn, o_Val_Rm, o_Shift_Operand, o_Immediate, o_Dest, o_Src1,
                  o_Src2, o_Exe_Cmd, o_Mem_Read, o_Mem_Write, o_WB_En, o_Set_Status, o_Branch,
                  o_Carry, o_Sig_Memory_Instruction};

  function automatic void check_vec(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  // Expected register contents after one edge, from the flush > freeze > load rules.
  function automatic logic [W-1:0] model(in_t v, logic fl, logic fz, logic [W-1:0] prev);
    logic [DW-1:0] rn, rm;
    logic ok;
    if (fl) return '0;
    if (fz) return prev;
    rn = v.rn;
    rm = v.rm;
`ifdef ID_EXE_WB_BYPASS_EN
    if (v.valid && v.byp_en && v.byp_dest != 4'hF) begin
      if (v.byp_dest == v.src1) rn = v.byp_val;
      if (v.byp_dest == v.src2) rm = v.byp_val;
    end
`endif
    ok = v.valid;
    return {v.valid, v.pc, rn, rm, v.shop, v.imm, v.dest, v.src1, v.src2, v.cmd,
            ok & v.mr, ok & v.mw, ok & v.wb, ok & v.ss, ok & v.br, v.carry, ok & (v.mr | v.mw)};
  endfunction

  function automatic in_t pat(logic [31:0] k);
    in_t v;
    v          = '0;
    v.valid    = 1'b1;
    v.pc       = 32'h0000_1000 + (k << 2);
    v.rn       = 32'hA5A5_0000 ^ k;
    v.rm       = ~k;
    v.shop     = k[11:0] ^ 12'h5A5;
    v.imm      = k[0];
    v.dest     = k[3:0];
    v.src1     = k[7:4];
    v.src2     = k[11:8];
    v.cmd      = k[15:12];
    v.carry    = k[1];
    v.byp_dest = 4'hF;
    return v;
  endfunction

  task automatic cycle(input in_t v, input logic fl, input logic fz);
    @(negedge clk);
    i_Valid = v.valid; i_PC = v.pc; i_Val_Rn = v.rn; i_Val_Rm = v.rm;
    i_Shift_Operand = v.shop; i_Immediate = v.imm; i_Dest = v.dest; i_Src1 = v.src1;
    i_Src2 = v.src2; i_Exe_Cmd = v.cmd; i_Mem_Read = v.mr; i_Mem_Write = v.mw;
    i_WB_En = v.wb; i_Set_Status = v.ss; i_Branch = v.br; i_Carry = v.carry;
    i_WB_Bypass_En = v.byp_en; i_WB_Bypass_Dest = v.byp_dest; i_WB_Bypass_Value = v.byp_val;
    i_Flush = fl; i_Freeze = fz;
    last_exp = model(v, fl, fz, last_exp);
    exp_q.push_back(last_exp);
  endtask

  // Monitor: every edge that has a queued expectation is compared one step later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check_vec("edge_out", act_w, exp_q.pop_front());
    end
  end

  initial begin
    in_t v;
    logic [DW-1:0] exp_rm;
    i_Reset = 1'b1; i_Freeze = 1'b1; i_Flush = 1'b0; i_Valid = 1'b0;
    i_PC = '0; i_Val_Rn = '0; i_Val_Rm = '0; i_Shift_Operand = '0; i_Immediate = 1'b0;
    i_Dest = '0; i_Src1 = '0; i_Src2 = '0; i_Exe_Cmd = '0; i_Mem_Read = 1'b0;
    i_Mem_Write = 1'b0; i_WB_En = 1'b0; i_Set_Status = 1'b0; i_Branch = 1'b0; i_Carry = 1'b0;
    i_WB_Bypass_En = 1'b0; i_WB_Bypass_Dest = '0; i_WB_Bypass_Value = '0;
    last_exp = '0;
    #2;
    check_vec("reset_state", act_w, '0);
    repeat (2) @(negedge clk);
    i_Reset = 1'b0;

    // Memory-read load with hand-checked fields.
    v = pat(32'h11); v.rm = 32'h0000_00F0; v.shop = 12'h104; v.mr = 1'b1;
    cycle(v, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("ld_val_rm", o_Val_Rm, 32'h0000_00F0);
    chk("ld_shift_op", {20'd0, o_Shift_Operand}, 32'h104);
    chk("ld_sig_mem", {31'd0, o_Sig_Memory_Instruction}, 32'd1);
    chk("ld_valid", {31'd0, o_Valid}, 32'd1);

    // Bubble with control bits presented: data captured, controls dropped.
    v = pat(32'h2345); v.valid = 1'b0; v.mr = 1'b1; v.mw = 1'b1; v.wb = 1'b1; v.ss = 1'b1; v.br = 1'b1;
    cycle(v, 1'b0, 1'b0);
    v = pat(32'h3C7A); v.mw = 1'b1; v.wb = 1'b1; v.ss = 1'b1; v.br = 1'b1;
    cycle(v, 1'b0, 1'b0);

    // Freeze for three edges with changing inputs, then release with newest inputs.
    for (int i = 0; i < 3; i++) begin
      v = pat(32'h500 + i); v.wb = 1'b1;
      cycle(v, 1'b0, 1'b1);
    end
    v = pat(32'h6A5); v.valid = 1'b1; v.br = 1'b1;
    cycle(v, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("frz_release_pc", o_PC, 32'h0000_1000 + (32'h6A5 << 2));

    // Flush wins over freeze.
    v = pat(32'h7777); v.wb = 1'b1;
    cycle(v, 1'b1, 1'b1);
    @(posedge clk); #2;
    chk("flush_valid", {31'd0, o_Valid}, 32'd0);
    chk("flush_wb", {31'd0, o_WB_En}, 32'd0);
    chk("flush_rn", o_Val_Rn, 32'd0);

    // Write-back bypass onto Src2.
    v = pat(32'h0312); v.src2 = 4'd3; v.rm = 32'h1;
    v.byp_en = 1'b1; v.byp_dest = 4'd3; v.byp_val = 32'hDEAD_BEEF;
    cycle(v, 1'b0, 1'b0);
`ifdef ID_EXE_WB_BYPASS_EN
    exp_rm = 32'hDEAD_BEEF;
`else
    exp_rm = 32'h1;
`endif
    @(posedge clk); #2;
    chk("byp_src2", o_Val_Rm, exp_rm);
    // Dest R15 is never forwarded.
    v.byp_dest = 4'hF; v.src2 = 4'hF;
    cycle(v, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("byp_r15", o_Val_Rm, 32'h1);
    // Both sources match, and a bubble that must not forward.
    v = pat(32'h9955); v.src1 = 4'd5; v.src2 = 4'd5;
    v.byp_en = 1'b1; v.byp_dest = 4'd5; v.byp_val = 32'h1234_5678;
    cycle(v, 1'b0, 1'b0);
    v.valid = 1'b0; v.byp_val = 32'hCAFE_F00D;
    cycle(v, 1'b0, 1'b0);
    v = pat(32'hBEEF); v.src1 = 4'd2; v.byp_en = 1'b1; v.byp_dest = 4'd2; v.byp_val = 32'h0BAD_0BAD;
    v.mw = 1'b1; v.ss = 1'b1;
    cycle(v, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle while a valid instruction sits in the register.
    v = pat(32'h4242); v.wb = 1'b1; v.mr = 1'b1;
    cycle(v, 1'b0, 1'b0);
    @(negedge clk);
    i_Freeze = 1'b1;
    @(posedge clk); #3;
    i_Reset = 1'b1;
    #1;
    check_vec("async_reset", act_w, '0);
    @(negedge clk);
    i_Reset = 1'b0;
    last_exp = '0;
    v = pat(32'h1357); v.br = 1'b1;
    cycle(v, 1'b0, 1'b0);
    v = pat(32'h2468);
    cycle(v, 1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_exe_register.md
ID_EXE_REGISTER -- requirements
Module: id_exe_register

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of PC and operand datapaths.
REQ-002 SHALL have port i_Clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port i_Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_Freeze  input  1  hazard/memory stall; hold all state.
REQ-005 SHALL have port i_Flush  input  1  branch taken; insert bubble.
REQ-006 SHALL have port i_Valid  input  1  ID stage holds a real instruction.
REQ-007 SHALL have port i_PC  input  DATA_WIDTH  instruction PC+4.
REQ-008 SHALL have ports i_Val_Rn, i_Val_Rm  input  DATA_WIDTH each  register-file read data.
REQ-009 SHALL have port i_Shift_Operand  input  12  shifter operand / memory offset field.
REQ-010 SHALL have port i_Immediate  input  1  I bit.
REQ-011 SHALL have ports i_Dest, i_Src1, i_Src2  input  4 each  register indices.
REQ-012 SHALL have port i_Exe_Cmd  input  4  ALU command.
REQ-013 SHALL have ports i_Mem_Read, i_Mem_Write, i_WB_En, i_Set_Status, i_Branch  input  1 each  control bits.
REQ-014 SHALL have port i_Carry  input  1  status-register C flag.
REQ-015 SHALL have ports i_WB_Bypass_En, i_WB_Bypass_Dest, i_WB_Bypass_Value  input  1/4/DATA_WIDTH  concurrent write-back.
REQ-016 SHALL have port o_<X>  output  same width as i_<X>  registered copy of every input in REQ-007..REQ-014.
REQ-017 SHALL have port o_Sig_Memory_Instruction  output  1  registered (i_Mem_Read | i_Mem_Write).
REQ-018 SHALL have port o_Valid  output  1  EXE stage holds a real instruction.

Function
REQ-019 SHALL capture all inputs on rising edge of i_Clk; latency exactly 1 cycle.
REQ-020 SHALL apply priority per edge: i_Reset > i_Flush > i_Freeze > load.
REQ-021 SHALL, on flush, clear o_Valid, o_Mem_Read, o_Mem_Write, o_WB_En, o_Set_Status, o_Branch, o_Sig_Memory_Instruction and all data outputs to 0.
REQ-022 SHALL, on freeze without flush, hold every output unchanged, including o_Valid.
REQ-023 SHALL, on load with i_Valid=0, clear o_Valid and all control bits of REQ-021 while capturing data fields as presented.
REQ-024 SHALL, on load with i_Valid=1, capture all fields unmodified except as REQ-029.
REQ-025 SHALL never assert o_Mem_Write, o_WB_En, o_Set_Status or o_Branch while o_Valid=0.
REQ-026 SHALL drive o_Shift_Operand, o_Immediate, o_Val_Rm and o_Sig_Memory_Instruction directly from flops, no combinational input-to-output path.
REQ-027 SHALL treat freeze deasserting on the same edge as new input: load that edge.

Reset
REQ-028 SHALL, while i_Reset=1, asynchronously force all outputs to 0, independent of i_Clk; first load on first rising edge after deassertion.

Configuration
REQ-029 SHALL, when ID_EXE_WB_BYPASS_EN is defined, on a valid load with i_WB_Bypass_En=1 and i_WB_Bypass_Dest != 4'hF, capture i_WB_Bypass_Value into o_Val_Rn if Dest==i_Src1 and into o_Val_Rm if Dest==i_Src2 (both if both match).
REQ-030 SHALL, when ID_EXE_WB_BYPASS_EN is undefined, ignore all i_WB_Bypass_* inputs and capture i_Val_Rn/i_Val_Rm unmodified.

Verification
REQ-031 SHALL cover: reset asserted mid-cycle with o_Valid=1 -> all outputs 0 immediately, before next edge.
REQ-032 SHALL cover: load i_Valid=1, i_Val_Rm=32'h0000_00F0, i_Shift_Operand=12'h104, i_Mem_Read=1 -> next cycle o_Val_Rm=32'h0000_00F0, o_Shift_Operand=12'h104, o_Sig_Memory_Instruction=1, o_Valid=1.
REQ-033 SHALL cover: i_Freeze=1 for 3 cycles with changing inputs -> outputs constant; freeze release -> newest inputs appear after 1 edge.
REQ-034 SHALL cover: i_Flush=1 and i_Freeze=1 same edge with i_WB_En=1 -> o_Valid=0, o_WB_En=0, o_Val_Rn=0.
REQ-035 SHALL cover: macro defined, i_Src2=4'd3, i_WB_Bypass_En=1, i_WB_Bypass_Dest=4'd3, i_WB_Bypass_Value=32'hDEAD_BEEF, i_Val_Rm=32'h1 -> o_Val_Rm=32'hDEAD_BEEF; macro undefined -> o_Val_Rm=32'h1; Dest=4'hF -> 32'h1 in both builds.
